adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder (power of two, 2..8).
REQ-002 Parameter W, default 16, operand/sum width in bits.
REQ-003 Parameter IDW, default 2, requester-ID width; SHALL equal log2(NREQ).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  NREQ  per-requester operation request.
REQ-007 Port req_ready  output  NREQ  per-requester acceptance; at most one bit set per cycle.
REQ-008 Port req_a  input  NREQ*W  packed operand A; requester i occupies bits [i*W+W-1 : i*W].
REQ-009 Port req_b  input  NREQ*W  packed operand B; same packing as req_a.
REQ-010 Port req_cin  input  NREQ  per-requester carry-in.
REQ-011 Port res_valid  output  1  result register holds a valid result.
REQ-012 Port res_ready  input  1  downstream consumer accepts the result.
REQ-013 Port res_sum  output  W  registered A+B+cin, modulo 2^W.
REQ-014 Port res_cout  output  1  registered carry-out of the addition.
REQ-015 Port res_id  output  IDW  index of the requester that owns the result.
REQ-016 Port op_count  output  16  count of accepted operations; wraps modulo 2^16.

Function
REQ-017 Output slot free = !res_valid | res_ready.
REQ-018 When the slot is free, the block SHALL grant the first requester with req_valid set, searching upward from rr_ptr with wrap-around; req_ready SHALL be one-hot on that requester.
REQ-019 When the slot is not free, or no req_valid bit is set, req_ready SHALL be all zeros.
REQ-020 req_ready SHALL be combinational from req_valid, rr_ptr and the slot-free condition, and SHALL NOT depend on req_ready itself.
REQ-021 Transfer occurs when req_valid[g] & req_ready[g]; the granted operands SHALL pass through the combinational prefix adder in the same cycle.
REQ-022 On transfer, the next edge SHALL load res_sum, res_cout, res_id=g and set res_valid=1; latency from request acceptance to result valid is 1 cycle.
REQ-023 On transfer, rr_ptr SHALL become (g+1) mod NREQ; otherwise rr_ptr holds.
REQ-024 If res_valid & res_ready with no new transfer, res_valid SHALL clear on the next edge.
REQ-025 If res_valid & res_ready with a new transfer in the same cycle, the result register SHALL reload back-to-back, sustaining 1 operation per cycle.
REQ-026 While res_valid & !res_ready, res_sum, res_cout and res_id SHALL hold stable.
REQ-027 On each transfer, op_count SHALL increment by 1; 16'hFFFF wraps to 0.
REQ-028 Fairness: a requester holding req_valid continuously SHALL be granted within NREQ transfers.
REQ-029 Requesters SHALL hold req_valid and operands stable until accepted; the block does not check this.

Reset
REQ-030 While rst=1 at a clock edge: res_valid=0, res_sum=0, res_cout=0, res_id=0, rr_ptr=0, op_count=0.
REQ-031 req_ready SHALL be all zeros whenever rst=1; a request pending at reset is discarded and not counted.
REQ-032 A result held in the output register is lost on reset mid-operation; no partial state survives reset.

Structure
REQ-033 A shared package SHALL define NREQ, W and IDW defaults and the requester-ID type.
REQ-034 Round-robin search and rr_ptr state SHALL form one sub-module, rr_arb, with outputs one-hot grant and encoded grant ID.
REQ-035 The adder SHALL be the team's W-bit Sklansky prefix adder, instantiated once and fed from an operand mux indexed by the encoded grant ID.

Verification
REQ-036 After reset, req_valid=4'b1111, res_ready=1 held -> grants in order 0,1,2,3,0; results one per cycle; op_count=5 after 5 transfers.
REQ-037 Requester 2 sends A=16'hFFFF, B=16'h0001, cin=0 -> next cycle res_sum=16'h0000, res_cout=1, res_id=2.
REQ-038 Requester 1 sends A=16'h1234, B=16'h4321, cin=1 with res_ready=0 for 3 cycles -> res_sum=16'h5556 held stable, req_ready=0 throughout, then released on res_ready=1.
REQ-039 rr_ptr=3 with only req_valid[0] and req_valid[3] set -> requester 3 granted first, then requester 0.
REQ-040 Assert rst while res_valid=1 and req_valid=4'b0100 -> next cycle res_valid=0, op_count=0, rr_ptr=0, and no grant while rst=1.
REQ-041 Preload op_count=16'hFFFF through 65535 transfers, then perform one more transfer -> op_count=0.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and types for the round-robin arbitrated adder.
package adder_arbiter_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 16;
   localparam int IDW_DEF  = 2;

   typedef logic [IDW_DEF-1:0] req_id_t;

endpackage

// File: rtl/adder_arbiter_rr_arb.sv
// Round-robin arbiter: searches upward from rr_ptr, wraps, advances past each winner.
module rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gid,
   output logic            gvalid
);

   logic [IDW-1:0] rr_ptr;

   always_comb begin
      // NOTE: every output gets a default first so no path through the loop leaves a latch.
      grant  = '0;
      gid    = '0;
      gvalid = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (en && !gvalid && req[rr_ptr + IDW'(k)]) begin
            gvalid = 1'b1;
            gid    = rr_ptr + IDW'(k);
         end
      end
      if (gvalid) grant = NREQ'(1) << gid;
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst)         rr_ptr <= '0;
      else if (gvalid) rr_ptr <= gid + IDW'(1);
   end

endmodule

// File: rtl/adder_arbiter_sklansky.sv
// W-bit Sklansky (divide-and-conquer) parallel-prefix adder with carry-in.
module sklansky_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int LV = $clog2(W);

   for (genvar l = 0; l <= LV; l++) begin : lvl
      logic [W-1:0] g;
      logic [W-1:0] p;
      if (l == 0) begin : init
         // Carry-in is folded into bit 0 so every group generate already includes it.
         assign g = {a[W-1:1] & b[W-1:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};
         assign p = a ^ b;
      end else begin : comb
         for (genvar i = 0; i < W; i++) begin : col
            if (((i >> (l - 1)) & 1) == 1) begin : merge
               localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
               assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[J]);
               assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[J];
            end else begin : pass
               assign g[i] = lvl[l-1].g[i];
               assign p[i] = lvl[l-1].p[i];
            end
         end
      end
   end

   logic unused_p;
   assign unused_p = ^lvl[LV].p;

   assign sum  = lvl[0].p ^ {lvl[LV].g[W-2:0], cin};
   assign cout = lvl[LV].g[W-1];

endmodule

// File: rtl/adder_arbiter.sv
// NREQ requesters share one prefix adder; a one-entry result register decouples the consumer.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int IDW  = IDW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic              res_cout,
   output logic [IDW-1:0]    res_id,
   output logic [15:0]       op_count
);

   logic           slot_free;
   logic           xfer;
   logic [IDW-1:0] gid;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           op_cin;
   logic [W-1:0]   sum;
   logic           cout;

   assign slot_free = !res_valid || res_ready;

   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (slot_free && !rst),
      .req    (req_valid),
      .grant  (req_ready),
      .gid    (gid),
      .gvalid (xfer)
   );

   assign op_a   = req_a[gid*W +: W];
   assign op_b   = req_b[gid*W +: W];
   assign op_cin = req_cin[gid];

   sklansky_adder #(
      .W (W)
   ) u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= '0;
         op_count  <= '0;
      end else begin
         if (xfer) begin
            res_valid <= 1'b1;
            res_sum   <= sum;
            res_cout  <= cout;
            res_id    <= gid;
            op_count  <= op_count + 16'd1;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arbitration order, arithmetic, stall, reset, counter wrap.
module tb_adder_arbiter;
   import adder_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_cin;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_sum;
   logic        res_cout;
   req_id_t     res_id;
   logic [15:0] op_count;

   int checks = 0;
   int errors = 0;

   adder_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Hand-computed table: requester i operands and expected {cout,sum}.
   logic [15:0] ta [4] = '{16'h0001, 16'h8000, 16'h00FF, 16'hFFFF};
   logic [15:0] tb [4] = '{16'h0002, 16'h8000, 16'h0F01, 16'hFFFF};
   logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [15:0] ts [4] = '{16'h0003, 16'h0000, 16'h1001, 16'hFFFF};
   logic        to [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_table();
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = ta[i];
         req_b[i*16 +: 16] = tb[i];
         req_cin[i]        = tc[i];
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
      load_table();
      step(); step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
      checks++; if ({res_cout, res_sum, res_id} !== 19'd0) begin errors++; $display("FAIL reset_result got %h/%b/%0d want 0", res_sum, res_cout, res_id); end
      checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", op_count); end
      req_valid = 4'b0000; rst = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      req_valid = 4'b1111; res_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
         step();
         checks++; if (res_valid !== 1'b1 || res_id !== req_id_t'(k % 4)) begin errors++; $display("FAIL rr_id%0d got v=%b id=%0d want v=1 id=%0d", k, res_valid, res_id, k % 4); end
         checks++; if (res_sum !== ts[k % 4] || res_cout !== to[k % 4]) begin errors++; $display("FAIL rr_sum%0d got %h/%b want %h/%b", k, res_sum, res_cout, ts[k % 4], to[k % 4]); end
      end
      checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL rr_count got %0d want 5", op_count); end
      req_valid = 4'b0000;
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", res_valid); end
   endtask

   task automatic test_carry();
      req_a[32 +: 16] = 16'hFFFF; req_b[32 +: 16] = 16'h0001; req_cin[2] = 1'b0;
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_grant got %b want 0100", req_ready); end
      step();
      checks++; if (res_sum !== 16'h0000 || res_cout !== 1'b1 || res_id !== 2'd2) begin errors++; $display("FAIL carry_result got %h/%b/%0d want 0000/1/2", res_sum, res_cout, res_id); end
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_stall();
      res_ready = 1'b0;
      req_a[16 +: 16] = 16'h1234; req_b[16 +: 16] = 16'h4321; req_cin[1] = 1'b1;
      req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_grant got %b want 0010", req_ready); end
      step();
      req_valid = 4'b0001;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (res_valid !== 1'b1 || res_sum !== 16'h5556 || res_cout !== 1'b0 || res_id !== 2'd1) begin errors++; $display("FAIL stall_hold%0d got v=%b %h/%b/%0d want 1 5556/0/1", k, res_valid, res_sum, res_cout, res_id); end
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d got %b want 0000", k, req_ready); end
         step();
      end
      res_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_release got %b want 0001", req_ready); end
      step();
      checks++; if (res_id !== 2'd0 || res_sum !== 16'h0003) begin errors++; $display("FAIL stall_b2b got %h/%0d want 0003/0", res_sum, res_id); end
      req_valid = 4'b0000;
      step();
      checks++; if (op_count !== 16'd8) begin errors++; $display("FAIL stall_count got %0d want 8", op_count); end
   endtask

   task automatic test_wrap_order();
      req_valid = 4'b0100;
      step();
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b want 1000", req_ready); end
      step();
      checks++; if (res_id !== 2'd3) begin errors++; $display("FAIL wrap_id3 got %0d want 3", res_id); end
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b want 0001", req_ready); end
      step();
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL wrap_id0 got %0d want 0", res_id); end
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b0;
      req_valid = 4'b0010;
      step();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got %b want 1", res_valid); end
      req_valid = 4'b0100; rst = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b want 0000", req_ready); end
      step();
      checks++; if (res_valid !== 1'b0 || op_count !== 16'd0 || res_sum !== 16'd0 || res_id !== 2'd0) begin errors++; $display("FAIL mid_clear got v=%b cnt=%0d sum=%h id=%0d want all 0", res_valid, op_count, res_sum, res_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_hold got %b want 0000", req_ready); end
      rst = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b want 0001", req_ready); end
      step();
      checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL mid_count got %0d want 1", op_count); end
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_op_wrap();
      rst = 1'b1;
      step();
      rst = 1'b0; req_valid = 4'b0001; res_ready = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_full got %h want ffff", op_count); end
      step();
      checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h want 0000", op_count); end
      req_valid = 4'b0000;
      step();
   endtask

   initial begin
      req_a = '0; req_b = '0; req_cin = '0;
      test_reset();
      test_round_robin();
      test_carry();
      load_table();
      test_stall();
      test_wrap_order();
      test_reset_mid();
      test_op_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
